cmd_link: RTL and testbench

Serial front end of the Knight's Tour robot: receives 8N1 UART bytes from the Bluetooth module, assembles two consecutive bytes (high then low) into a 16-bit command, and presents it to the command processor with a `cmd_rdy`/`clr_cmd_rdy` handshake. It also transmits a single acknowledge byte back to the host whenever the command processor pulses `send_resp`. It sits directly upstream of the command processor.

---
 rtl/cmd_link.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_cmd_link.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/cmd_link.sv
// cmd_link: UART command front end.
//   Receives 8N1 bytes on rx_i, pairs them (high byte, then low byte) into
//   a 16-bit command with a cmd_rdy/clr_cmd_rdy handshake, and transmits a
//   fixed acknowledge byte on tx_o for each send_resp request.
//
// Ports
//   clk_i          system clock
//   rst_n_i        asynchronous active-low reset
//   rx_i           serial input, idle high (asynchronous)
//   tx_o           serial output, idle high
//   cmd_o          assembled command, [15:8] = first byte received
//   cmd_rdy_o      a complete command is held in cmd_o
//   clr_cmd_rdy_i  consumer pulse, drops cmd_rdy_o
//   send_resp_i    request one RESP frame
//   resp_sent_o    pulse in the last cycle of the response stop bit
//
// Optional feature: define CMD_TIMEOUT_EN to abandon a lone high byte
// after TIMEOUT_CYC idle cycles in the LOW state.
//
// state     | meaning
// RX_IDLE   | waiting for a falling edge on the synchronized line
// RX_START  | half-bit wait, re-check start bit (glitch reject)
// RX_DATA   | sampling 8 data bits, LSB first
// RX_STOP   | sampling stop bit; 1 = byte valid, 0 = framing error
// TX_IDLE   | line high, waiting for a request or the pending flag
// TX_START  | driving start bit
// TX_DATA   | shifting RESP out, LSB first
// TX_STOP   | driving stop bit, resp_sent_o on its final cycle
// ASM_HIGH  | next valid byte is the command high byte
// ASM_LOW   | next valid byte completes the command
module cmd_link #(
  parameter int          BAUD_DIV    = 2604,
  parameter logic [7:0]  RESP        = 8'hA5,
  parameter logic [23:0] TIMEOUT_CYC = 24'd2_500_000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        rx_i,
  output logic        tx_o,
  output logic [15:0] cmd_o,
  output logic        cmd_rdy_o,
  input  logic        clr_cmd_rdy_i,
  input  logic        send_resp_i,
  output logic        resp_sent_o
);

  localparam logic [11:0] BIT_TC  = 12'(BAUD_DIV - 1);
  localparam logic [11:0] HALF_TC = 12'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic       {ASM_HIGH, ASM_LOW} asm_state_e;

  // ---------------- RX ----------------
  logic        rx_ff1_q, rx_ff2_q, rx_prev_q;
  rx_state_e   rx_state_q, rx_state_d;
  logic [11:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_vld_q, rx_vld_d;
  logic        rx_tc;

  assign rx_tc = (rx_cnt_q == 12'd0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_ff1_q   <= 1'b1;
      rx_ff2_q   <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= 12'd0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_vld_q   <= 1'b0;
    end else begin
      rx_ff1_q   <= rx_i;
      rx_ff2_q   <= rx_ff1_q;
      // previous synchronized value, only for falling-edge detection
      rx_prev_q  <= rx_ff2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_vld_q   <= rx_vld_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_tc ? rx_cnt_q : rx_cnt_q - 12'd1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_ff2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = HALF_TC;
        end
      end
      RX_START: begin
        if (rx_tc) begin
          if (rx_ff2_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            rx_cnt_d   = BIT_TC;
            rx_bit_d   = 3'd0;
          end
        end
      end
      RX_DATA: begin
        if (rx_tc) begin
          rx_shift_d = {rx_ff2_q, rx_shift_q[7:1]};
          rx_cnt_d   = BIT_TC;
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_tc) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_vld_d = (rx_state_q == RX_STOP) && rx_tc && rx_ff2_q;
  end

  // ---------------- TX ----------------
  tx_state_e   tx_state_q, tx_state_d;
  logic [11:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_pend_q, tx_pend_d;
  logic        tx_q, tx_d;
  logic        tx_tc;

  assign tx_tc = (tx_cnt_q == 12'd0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= 12'd0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      tx_pend_q  <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_pend_q  <= tx_pend_d;
      tx_q       <= tx_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_tc ? tx_cnt_q : tx_cnt_q - 12'd1;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pend_d  = tx_pend_q;
    // a request while busy parks in the single-entry pending flag
    if (send_resp_i && tx_state_q != TX_IDLE) tx_pend_d = 1'b1;
    case (tx_state_q)
      TX_IDLE: begin
        if (send_resp_i || tx_pend_q) begin
          tx_state_d = TX_START;
          tx_cnt_d   = BIT_TC;
          tx_shift_d = RESP;
          tx_pend_d  = 1'b0;
        end
      end
      TX_START: begin
        if (tx_tc) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = BIT_TC;
          tx_bit_d   = 3'd0;
        end
      end
      TX_DATA: begin
        if (tx_tc) begin
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_cnt_d   = BIT_TC;
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_tc) begin
          // chain the pending frame with no idle gap
          if (tx_pend_q) begin
            tx_state_d = TX_START;
            tx_cnt_d   = BIT_TC;
            tx_shift_d = RESP;
            tx_pend_d  = 1'b0;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    case (tx_state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = tx_shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx_o        = tx_q;
  assign resp_sent_o = (tx_state_q == TX_STOP) && tx_tc;

  // ---------------- assembler ----------------
  asm_state_e  asm_state_q, asm_state_d;
  logic [15:0] cmd_q, cmd_d;
  logic        cmd_rdy_q, cmd_rdy_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      asm_state_q <= ASM_HIGH;
      cmd_q       <= 16'h0000;
      cmd_rdy_q   <= 1'b0;
    end else begin
      asm_state_q <= asm_state_d;
      cmd_q       <= cmd_d;
      cmd_rdy_q   <= cmd_rdy_d;
    end
  end

`ifdef CMD_TIMEOUT_EN
  logic [23:0] to_cnt_q, to_cnt_d;
  logic        to_hit;

  assign to_hit = (asm_state_q == ASM_LOW) && (to_cnt_q == TIMEOUT_CYC);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) to_cnt_q <= 24'd0;
    else          to_cnt_q <= to_cnt_d;
  end

  always_comb begin
    to_cnt_d = (rx_vld_q || asm_state_d == ASM_HIGH) ? 24'd0 : to_cnt_q + 24'd1;
  end
`else
  logic to_hit;
  // no timeout hardware; parameter kept so both builds share one interface
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign to_hit = 1'b0;
`endif

  always_comb begin
    asm_state_d = asm_state_q;
    cmd_d       = cmd_q;
    cmd_rdy_d   = cmd_rdy_q;
    if (clr_cmd_rdy_i) cmd_rdy_d = 1'b0;
    // a completing low byte overrides a same-cycle clear
    if (rx_vld_q) begin
      if (asm_state_q == ASM_HIGH) begin
        cmd_d[15:8] = rx_shift_q;
        cmd_rdy_d   = 1'b0;
        asm_state_d = ASM_LOW;
      end else begin
        cmd_d[7:0]  = rx_shift_q;
        cmd_rdy_d   = 1'b1;
        asm_state_d = ASM_HIGH;
      end
    end else if (to_hit) begin
      asm_state_d = ASM_HIGH;
    end
  end

  assign cmd_o     = cmd_q;
  assign cmd_rdy_o = cmd_rdy_q;

endmodule

// File: tb/tb_cmd_link.sv
module tb_cmd_link;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        tx;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic        resp_sent;

  int total = 0;
  int bad   = 0;

  logic mon_en = 1'b0;
  int   mon_cnt = 0;

  always #5 clk = ~clk;

  cmd_link #(.BAUD_DIV(16), .RESP(8'hA5), .TIMEOUT_CYC(24'd500)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .rx_i(rx), .tx_o(tx),
    .cmd_o(cmd), .cmd_rdy_o(cmd_rdy), .clr_cmd_rdy_i(clr_cmd_rdy),
    .send_resp_i(send_resp), .resp_sent_o(resp_sent)
  );

  always @(negedge clk) if (mon_en && cmd_rdy) mon_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(negedge clk);
    end
    rx = stop;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [9:0] bits;
    int first, second, pulses;
    logic tx161;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_cmd", cmd, 16'h0000);
    chk("rst_rdy", cmd_rdy, 1'b0);
    chk("rst_resp_sent", resp_sent, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // test 1: basic command and clear
    send_byte(8'h40, 1'b1);
    chk("t1_hi_rdy", cmd_rdy, 1'b0);
    send_byte(8'h25, 1'b1);
    chk("t1_cmd", cmd, 16'h4025);
    chk("t1_rdy", cmd_rdy, 1'b1);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    chk("t1_clr_rdy", cmd_rdy, 1'b0);
    chk("t1_clr_cmd", cmd, 16'h4025);

    // set wins over a clear held across the completing low byte
    send_byte(8'h12, 1'b1);
    clr_cmd_rdy = 1'b1;
    mon_en = 1'b1;
    send_byte(8'h34, 1'b1);
    mon_en = 1'b0;
    clr_cmd_rdy = 1'b0;
    chk("setwins_cycles", mon_cnt, 1);
    chk("setwins_cmd", cmd, 16'h1234);
    chk("setwins_rdy_after", cmd_rdy, 1'b0);

    // test 2: overwrite without clear
    send_byte(8'h20, 1'b1);
    send_byte(8'h00, 1'b1);
    chk("t2_cmd_a", cmd, 16'h2000);
    chk("t2_rdy_a", cmd_rdy, 1'b1);
    send_byte(8'h60, 1'b1);
    chk("t2_rdy_hi", cmd_rdy, 1'b0);
    chk("t2_cmd_hi", cmd, 16'h6000);
    send_byte(8'h11, 1'b1);
    chk("t2_cmd_b", cmd, 16'h6011);
    chk("t2_rdy_b", cmd_rdy, 1'b1);

    // test 3: single response frame
    bits = '0;
    first = 0;
    send_resp = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) send_resp = 1'b0;
      if (c % 16 == 8 && c <= 152) bits[(c - 8) / 16] = tx;
      if (resp_sent && first == 0) first = c;
    end
    chk("t3_frame_bits", bits, 10'b1101001010);
    chk("t3_resp_sent_at", (first >= 159 && first <= 161), 1'b1);
    chk("t3_tx_idle", tx, 1'b1);

    // test 4: pending request, third request dropped
    first = 0; second = 0; pulses = 0; tx161 = 1'b1;
    send_resp = 1'b1;
    for (int c = 1; c <= 520; c++) begin
      @(negedge clk);
      if (c == 1 || c == 41 || c == 81) send_resp = 1'b0;
      if (c == 40 || c == 80) send_resp = 1'b1;
      if (c == 161) tx161 = tx;
      if (resp_sent) begin
        pulses++;
        if (first == 0) first = c;
        else if (second == 0) second = c;
      end
    end
    chk("t4_pulses", pulses, 2);
    chk("t4_gap", second - first, 160);
    chk("t4_back_to_back_start", tx161, 1'b0);

    // test 5: framing error, then glitch
    send_byte(8'h55, 1'b0);
    chk("t5_ferr_cmd", cmd, 16'h6011);
    chk("t5_ferr_rdy", cmd_rdy, 1'b1);
    send_byte(8'h40, 1'b1);
    send_byte(8'h01, 1'b1);
    chk("t5_cmd", cmd, 16'h4001);
    chk("t5_rdy", cmd_rdy, 1'b1);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    chk("t5_glitch_cmd", cmd, 16'h4001);
    chk("t5_glitch_rdy", cmd_rdy, 1'b1);
    send_byte(8'h7E, 1'b1);
    chk("t5_after_glitch_hi", cmd, 16'h7E01);
    chk("t5_after_glitch_rdy", cmd_rdy, 1'b0);
    send_byte(8'h99, 1'b1);
    chk("t5_after_glitch_cmd", cmd, 16'h7E99);

    // test 6: inter-byte timeout
    send_byte(8'h40, 1'b1);
    repeat (600) @(negedge clk);
    send_byte(8'h12, 1'b1);
`ifdef CMD_TIMEOUT_EN
    chk("t6_mid_cmd", cmd, 16'h1299);
    chk("t6_mid_rdy", cmd_rdy, 1'b0);
    send_byte(8'h34, 1'b1);
    chk("t6_cmd", cmd, 16'h1234);
    chk("t6_rdy", cmd_rdy, 1'b1);
`else
    chk("t6_mid_cmd", cmd, 16'h4012);
    chk("t6_mid_rdy", cmd_rdy, 1'b1);
    send_byte(8'h34, 1'b1);
    chk("t6_cmd", cmd, 16'h3412);
    chk("t6_rdy", cmd_rdy, 1'b0);
    // leave the assembler in HIGH for the next step
    send_byte(8'h00, 1'b1);
`endif

    // reset mid-frame: partial command and TX frame both lost
    send_byte(8'h77, 1'b1);
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    repeat (39) @(negedge clk);
    chk("rst_mid_tx_busy", tx, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_tx", tx, 1'b1);
    chk("rst_mid_cmd", cmd, 16'h0000);
    chk("rst_mid_rdy", cmd_rdy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_mid_tx_stays_idle", tx, 1'b1);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    chk("rst_mid_cmd_after", cmd, 16'hABCD);
    chk("rst_mid_rdy_after", cmd_rdy, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
